// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the eight-way round-robin arbiter.
//   NUM_REQ     - number of requesters sharing the resource
//   IDX_W       - width of an encoded requester index
//   arb_state_t - arbiter state encoding (IDLE / GRANT / GAP)
package rr_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter8_grant_decoder.sv
// grant_decoder: combinational 3-to-8 one-hot decoder with enable.
//   idx    in  3  encoded owner index
//   en     in  1  decoder enable; output is all zero when low
//   onehot out 8  one-hot select vector
module grant_decoder (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for one shared eight-way one-hot resource.
// Tracks the current owner, limits ownership to MAX_HOLD cycles, inserts a
// one-cycle gap between owners and rotates priority past the last owner.
//   Clock   in  1  rising-edge clock
//   Reset   in  1  synchronous, active-high reset
//   EN      in  1  arbitration enable (gates new grants only)
//   Req     in  8  request vector; Req[i] high = requester i wants/keeps ownership
//   Gnt     out 8  registered one-hot grant, zero when there is no owner
//   GntIdx  out 3  encoded owner index, meaningful while Busy is high
//   Busy    out 1  high while a grant is held
//   Timeout out 1  one-cycle pulse during the gap that follows a forced revoke
//
// Request/grant semantics: a requester asserts Req[i] and keeps it high for as
// long as it wants the resource; ownership starts in the cycle Gnt[i] is seen
// high and ends when the requester drops Req[i] (or is revoked after MAX_HOLD
// cycles). There is always at least one Gnt=0 cycle between two owners.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       EN,
    input  logic [7:0] Req,
    output logic [7:0] Gnt,
    output logic [2:0] GntIdx,
    output logic       Busy,
    output logic       Timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    arb_state_t       state_nxt;
    logic [2:0]       ptr_nxt;
    logic [2:0]       idx_nxt;
    logic [CNT_W-1:0] hold_nxt;
    logic             busy_nxt;
    logic             tmo_nxt;
    logic [2:0]       win_idx;
    logic [7:0]       gnt_dec;

    // First set request bit in the order ptr, ptr+1, ..., ptr+7 (mod 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
        logic [2:0] cand;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + i[2:0];
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign win_idx = rr_pick(Req, ptr);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = GntIdx;
        hold_nxt  = hold_cnt;
        busy_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (EN && (Req != 8'h00)) begin
                    state_nxt = GRANT;
                    idx_nxt   = win_idx;
                    hold_nxt  = '0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!Req[GntIdx]) begin
                    // Voluntary release takes precedence over the hold limit.
                    state_nxt = GAP;
                    ptr_nxt   = GntIdx + 3'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = GAP;
                    ptr_nxt   = GntIdx + 3'd1;
                    tmo_nxt   = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt + 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Decode the next owner so that Gnt is registered yet lines up with Busy.
    grant_decoder u_grant_decoder (
        .idx    (idx_nxt),
        .en     (busy_nxt),
        .onehot (gnt_dec)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            GntIdx   <= 3'd0;
            Gnt      <= 8'h00;
            Busy     <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            GntIdx   <= idx_nxt;
            Gnt      <= gnt_dec;
            Busy     <= busy_nxt;
            Timeout  <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: self-checking bench for rr_arbiter8 (MAX_HOLD = 4).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// run, all compared against a behavioural ownership model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       tmo;

    always #5 clk = ~clk;

    rr_arbiter8 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .Clock   (clk),
        .Reset   (rst),
        .EN      (en),
        .Req     (req),
        .Gnt     (gnt),
        .GntIdx  (gnt_idx),
        .Busy    (busy),
        .Timeout (tmo)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Ownership view: who owns the resource, how many Gnt cycles it has had,
    // where the rotation starts next time, and the last index handed out.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_last  = 0;
    bit m_tmo   = 1'b0;

    logic [7:0] exp_q[$];

    function automatic int pick(int start, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_step(bit r, bit e, logic [7:0] q);
        m_tmo = 1'b0;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_last  = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (e && q != 8'h00) begin
            m_owner = pick(m_ptr, q);
            m_last  = m_owner;
            m_held  = 1;
        end
    endfunction

    function automatic logic [7:0] model_gnt();
        logic [7:0] v;
        v = 8'h00;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input bit r, input bit e, input logic [7:0] q);
        logic [7:0] eg;
        rst = r;
        en  = e;
        req = q;
        model_step(r, e, q);
        exp_q.push_back(model_gnt());
        @(posedge clk);
        #1;
        eg = exp_q.pop_front();
        check("model_gnt", int'(gnt), int'(eg));
        check("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        check("model_tmo", int'(tmo), int'(m_tmo));
        if (m_owner >= 0) check("model_idx", int'(gnt_idx), m_last);
        check("onehot0", int'($countones(gnt) <= 1), 1);
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        bit         busy;
        bit         tmo;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [7:0] q;
        logic [7:0] prev;
        int         o;

        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;

        // reset, first grant, timeout and fairness after revoke
        tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h08, 8'h00, 3'd3, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h09, 8'h00, 3'd3, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req);
            check($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("tbl%0d_idx", i), int'(gnt_idx), int'(tbl[i].idx));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("tbl%0d_tmo", i), int'(tmo), int'(tbl[i].tmo));
        end

        // rotation: all request, each owner releases after 3 cycles
        step(1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        check("rot_first", int'(gnt), 8'h01);
        for (int k = 0; k < 8; k++) begin
            o = k;
            step(1'b0, 1'b1, 8'hFF);
            step(1'b0, 1'b1, 8'hFF);
            check($sformatf("rot%0d_held", k), int'(gnt), 1 << o);
            q = 8'hFF;
            q[o] = 1'b0;
            step(1'b0, 1'b1, q);
            check($sformatf("rot%0d_gap", k), int'(gnt), 0);
            step(1'b0, 1'b1, 8'hFF);
            check($sformatf("rot%0d_next", k), int'(gnt), 1 << ((o + 1) % 8));
        end

        // EN gating
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h20);
        check("en_block", int'(gnt), 0);
        step(1'b0, 1'b1, 8'h20);
        check("en_grant", int'(gnt), 8'h20);
        step(1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h20);
        check("en_keep", int'(gnt), 8'h20);
        step(1'b0, 1'b0, 8'h00);
        check("en_release", int'(gnt), 0);
        step(1'b0, 1'b0, 8'h20);
        check("en_gap_block", int'(gnt), 0);

        // reset mid-grant
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h40);
        check("mid_grant", int'(gnt), 8'h40);
        step(1'b1, 1'b1, 8'h40);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_tmo", int'(tmo), 0);
        step(1'b0, 1'b1, 8'h41);
        check("mid_rst_ptr", int'(gnt), 8'h01);

        // randomized traffic against the model
        prev = 8'hFF;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) != 0) q = prev;
            else q = 8'($urandom);
            if ($urandom_range(0, 5) == 0 && m_owner >= 0) q[m_owner] = 1'b0;
            prev = q;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
